ps2_device_tx: RTL

//  Device-to-host PS/2 transmitter for the keyboard FPGA. Serializes one byte per request into an
//  11-bit frame (start 0, D0..D7 LSB first, odd parity, stop 1) by pulling the open-drain clock and

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_line_sync.sv | 28 ++
 rtl/ps2_device_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry, transmitter state encoding and frame builder.
// Used by the device transmitter, receiver and reset/response blocks.
package ps2_pkg;

    localparam int FRAME_BITS   = 11;
    localparam int STOP_INDEX   = 10;
    localparam int PARITY_INDEX = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_IDLE = 3'd1,
        ST_BIT_HIGH  = 3'd2,
        ST_BIT_LOW   = 3'd3,
        ST_TAIL      = 3'd4
    } tx_state_t;

    // Bit 0 goes out first: start, D0..D7, odd parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data lines.
// Resets to the idle (high) level so reset release never looks like host activity.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic clk_raw,
    input  logic data_raw,
    output logic clk_sync,
    output logic data_sync
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_ff  <= 2'b11;
            data_ff <= 2'b11;
        end else begin
            clk_ff  <= {clk_ff[0], clk_raw};
            data_ff <= {data_ff[0], data_raw};
        end
    end

    assign clk_sync  = clk_ff[1];
    assign data_sync = data_ff[1];

endmodule

// File: rtl/ps2_device_tx.sv
// Device-to-host PS/2 transmitter: one byte per request, 11-bit frame on open-drain lines.
// Optional macro PS2_TX_RETRY_EN: resend the latched byte after a host-inhibit abort.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 400,
    parameter int IDLE_CYCLES = 1000,
    parameter int BIT_WIDTH   = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_abort,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_pull_down,
    output logic       ps2_data_pull_down
);

    localparam logic [BIT_WIDTH-1:0] HALF_LOAD = BIT_WIDTH'(HALF_PERIOD - 1);
    localparam logic [BIT_WIDTH-1:0] IDLE_LOAD = BIT_WIDTH'(IDLE_CYCLES - 1);
    localparam logic [3:0]           LAST_BIT  = 4'(STOP_INDEX);

    tx_state_t              state;
    logic [BIT_WIDTH-1:0]   cnt;
    logic [FRAME_BITS-1:0]  shift;
    logic [3:0]             bit_idx;
    logic                   clk_s;
    logic                   data_s;
`ifdef PS2_TX_RETRY_EN
    logic [7:0]             data_byte;
`endif

    ps2_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .clk_raw   (ps2_clk_in),
        .data_raw  (ps2_data_in),
        .clk_sync  (clk_s),
        .data_sync (data_s)
    );

    // Handshake: a byte transfers on a rising edge where tx_valid && tx_ready; tx_ready is
    // high only in IDLE, the source holds tx_valid and tx_data stable until that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            shift              <= '0;
            bit_idx            <= '0;
            ps2_clk_pull_down  <= 1'b0;
            ps2_data_pull_down <= 1'b0;
            tx_ready           <= 1'b1;
            tx_done            <= 1'b0;
            tx_abort           <= 1'b0;
            busy               <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            data_byte          <= '0;
`endif
        end else begin
            tx_done  <= 1'b0;
            tx_abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        shift    <= build_frame(tx_data);
                        cnt      <= IDLE_LOAD;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_WAIT_IDLE;
`ifdef PS2_TX_RETRY_EN
                        data_byte <= tx_data;
`endif
                    end
                end
                ST_WAIT_IDLE: begin
                    // Any low on either line restarts the idle qualification window.
                    if (!(clk_s && data_s)) begin
                        cnt <= IDLE_LOAD;
                    end else if (cnt == '0) begin
                        bit_idx            <= '0;
                        cnt                <= HALF_LOAD;
                        ps2_data_pull_down <= ~shift[0];
                        state              <= ST_BIT_HIGH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_BIT_HIGH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!clk_s && bit_idx != LAST_BIT) begin
                        ps2_clk_pull_down  <= 1'b0;
                        ps2_data_pull_down <= 1'b0;
                        tx_abort           <= 1'b1;
`ifdef PS2_TX_RETRY_EN
                        shift <= build_frame(data_byte);
                        cnt   <= IDLE_LOAD;
                        state <= ST_WAIT_IDLE;
`else
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
`endif
                    end else begin
                        ps2_clk_pull_down <= 1'b1;
                        cnt               <= HALF_LOAD;
                        state             <= ST_BIT_LOW;
                    end
                end
                ST_BIT_LOW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        ps2_clk_pull_down <= 1'b0;
                        cnt               <= HALF_LOAD;
                        if (bit_idx == LAST_BIT) begin
                            ps2_data_pull_down <= 1'b0;
                            state              <= ST_TAIL;
                        end else begin
                            bit_idx            <= bit_idx + 1'b1;
                            shift              <= {1'b0, shift[FRAME_BITS-1:1]};
                            ps2_data_pull_down <= ~shift[1];
                            state              <= ST_BIT_HIGH;
                        end
                    end
                end
                ST_TAIL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        tx_done  <= 1'b1;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    ps2_clk_pull_down  <= 1'b0;
                    ps2_data_pull_down <= 1'b0;
                    tx_ready           <= 1'b1;
                    busy               <= 1'b0;
                    state              <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
